// File: rtl/fpu_dispatch_unit_pkg.sv
// Shared opcodes, timeout default and FSM state type for the FPU dispatcher.
// Imported by the dispatcher top and by anything that drives or checks it.
package fpu_dispatch_unit_pkg;

  localparam logic [1:0] FPU_ADD  = 2'd0;
  localparam logic [1:0] FPU_SUB  = 2'd1;
  localparam logic [1:0] FPU_MUL  = 2'd2;
  localparam logic [1:0] FPU_SQRT = 2'd3;

  localparam int FPU_DISPATCH_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } disp_state_t;

  // A negative radicand can never produce a valid root, so it completes without the FPU.
  function automatic logic is_neg_sqrt(input logic [1:0] op, input logic sign_bit);
    return (op == FPU_SQRT) && sign_bit;
  endfunction

endpackage

// File: rtl/fpu_dispatch_unit_if.sv
// Request, FPU and write-back signals of the dispatcher bundled as one interface.
// Request: req_valid/req_ready handshake, transfer when both are high on a rising edge;
// the requester holds req_* stable while req_valid is high and req_ready is low.
interface fpu_dispatch_unit_if #(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 5
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_operation;
  logic [WIDTH-1:0]   req_operand_1;
  logic [WIDTH-1:0]   req_operand_2;
  logic [RD_BITS-1:0] req_rd;

  logic [1:0]         fpu_operation;
  logic [WIDTH-1:0]   fpu_operand_1;
  logic [WIDTH-1:0]   fpu_operand_2;
  logic [WIDTH-1:0]   fpu_result;
  logic               fpu_ready;

  logic               wb_valid;
  logic [RD_BITS-1:0] wb_rd;
  logic [WIDTH-1:0]   wb_data;
  logic               wb_error;

  modport master (
    input  req_valid, req_operation, req_operand_1, req_operand_2, req_rd,
    input  fpu_result, fpu_ready,
    output req_ready, fpu_operation, fpu_operand_1, fpu_operand_2,
    output wb_valid, wb_rd, wb_data, wb_error
  );

  modport slave (
    output req_valid, req_operation, req_operand_1, req_operand_2, req_rd,
    output fpu_result, fpu_ready,
    input  req_ready, fpu_operation, fpu_operand_1, fpu_operand_2,
    input  wb_valid, wb_rd, wb_data, wb_error
  );

endinterface

// File: rtl/fpu_dispatch_unit_timer.sv
// Cycle counter for the WAIT state: cleared on issue, counts while enabled, and
// flags expiry once it has reached TIMEOUT-1.
module fpu_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q, count_d;

  assign expired = (count_q == CW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fpu_dispatch_unit.sv
// Issues one fixed-point op to the FPU, holds operands until the FPU is ready, and
// returns the result (or a timeout / negative-radicand error) as a one-cycle write-back.
module fpu_dispatch_unit
  import fpu_dispatch_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FBITS   = 10,
  parameter int RD_BITS = 5,
  parameter int TIMEOUT = FPU_DISPATCH_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  fpu_dispatch_unit_if.master  bus,
  output disp_state_t          dbg_state
);

  generate
    if (TIMEOUT < 2) begin : g_bad_timeout
      $error("fpu_dispatch_unit: TIMEOUT must be at least 2");
    end
    if (FBITS >= WIDTH) begin : g_bad_fbits
      $error("fpu_dispatch_unit: FBITS must be smaller than WIDTH");
    end
  endgenerate

  disp_state_t        state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic [1:0]         fpu_op_q, fpu_op_d;
  logic [WIDTH-1:0]   fpu_op1_q, fpu_op1_d;
  logic [WIDTH-1:0]   fpu_op2_q, fpu_op2_d;
  logic [RD_BITS-1:0] tag_q, tag_d;
  logic               wb_valid_q, wb_valid_d;
  logic [RD_BITS-1:0] wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0]   wb_data_q, wb_data_d;
  logic               wb_error_q, wb_error_d;

  logic timer_clear, timer_en, timer_expired;

  assign timer_clear = (state_q == ST_ISSUE);
  assign timer_en    = (state_q == ST_WAIT);

  fpu_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    fpu_op_d   = fpu_op_q;
    fpu_op1_d  = fpu_op1_q;
    fpu_op2_d  = fpu_op2_q;
    tag_d      = tag_q;
    wb_valid_d = 1'b0;
    wb_error_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          fpu_op_d  = bus.req_operation;
          fpu_op1_d = bus.req_operand_1;
          fpu_op2_d = bus.req_operand_2;
          tag_d     = bus.req_rd;
          if (is_neg_sqrt(bus.req_operation, bus.req_operand_1[WIDTH-1])) begin
            state_d    = ST_WB;
            wb_valid_d = 1'b1;
            wb_error_d = 1'b1;
            wb_data_d  = '0;
            wb_rd_d    = bus.req_rd;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      // Ready may still be high from the previous op here, so it is not looked at.
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // Equality compare keeps an undriven or unknown ready from completing the op.
        if (bus.fpu_ready == 1'b1) begin
          state_d    = ST_WB;
          wb_valid_d = 1'b1;
          wb_data_d  = bus.fpu_result;
          wb_rd_d    = tag_q;
        end else if (timer_expired) begin
          state_d    = ST_WB;
          wb_valid_d = 1'b1;
          wb_error_d = 1'b1;
          wb_data_d  = '0;
          wb_rd_d    = tag_q;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      fpu_op_q    <= FPU_ADD;
      fpu_op1_q   <= '0;
      fpu_op2_q   <= '0;
      tag_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      fpu_op_q    <= fpu_op_d;
      fpu_op1_q   <= fpu_op1_d;
      fpu_op2_q   <= fpu_op2_d;
      tag_q       <= tag_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_error_q  <= wb_error_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.fpu_operation = fpu_op_q;
  assign bus.fpu_operand_1 = fpu_op1_q;
  assign bus.fpu_operand_2 = fpu_op2_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.wb_error      = wb_error_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_fpu_dispatch_unit.sv
// Bench for fpu_dispatch_unit: a fixed-point FPU model with programmable ready delay,
// directed corner cases, then randomized ops checked through an expected-queue scoreboard.
module tb_fpu_dispatch_unit;
  import fpu_dispatch_unit_pkg::*;

  localparam int WIDTH   = 32;
  localparam int FBITS   = 10;
  localparam int RD_BITS = 5;
  localparam int TIMEOUT = 64;
  localparam int EXP_W   = 32 + 1 + RD_BITS + WIDTH;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_dispatch_unit_if #(.WIDTH(WIDTH), .RD_BITS(RD_BITS)) bus ();
  disp_state_t dbg_state;

  fpu_dispatch_unit #(
    .WIDTH(WIDTH), .FBITS(FBITS), .RD_BITS(RD_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];
  int next_free = 0;

  logic [1:0]       last_op;
  logic [WIDTH-1:0] last_a, last_b;
  bit               hold_chk  = 1'b0;
  int               hold_from = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Fixed-point arithmetic with FBITS fraction bits; also used as the FPU model.
  function automatic logic [WIDTH-1:0] fx_ref(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    longint p, x, r, t;
    case (op)
      FPU_ADD: return a + b;
      FPU_SUB: return a - b;
      FPU_MUL: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return WIDTH'(p >>> FBITS);
      end
      default: begin
        x = longint'({32'b0, a}) << FBITS;
        r = 0;
        for (int i = 22; i >= 0; i--) begin
          t = r | (longint'(1) << i);
          if (t * t <= x) r = t;
        end
        return WIDTH'(r);
      end
    endcase
  endfunction

  // ---------------- FPU model ----------------
  // Ready is high in the accept and issue cycles (stale/comb), then low for cfg_delay
  // WAIT cycles; cfg_delay < 0 never readies. Result is junk unless ready in WAIT.
  int   acc_cyc   = -1000;
  int   cfg_delay = 0;
  int   rel;
  logic fpu_rdy;

  always_comb begin
    rel     = cyc - acc_cyc;
    fpu_rdy = (rel < 2) || (cfg_delay >= 0 && (rel - 2) >= cfg_delay);
  end

  assign bus.fpu_ready  = fpu_rdy;
  assign bus.fpu_result = (fpu_rdy && rel >= 2)
                          ? fx_ref(bus.fpu_operation, bus.fpu_operand_1, bus.fpu_operand_2)
                          : 32'hDEAD_BEEF;

  // ---------------- driver ----------------
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [RD_BITS-1:0] rd,
                       input int delay);
    int start, k, lat, waited, exp_acc;
    logic err;
    logic [WIDTH-1:0] d;
    @(negedge clk);
    bus.req_valid     = 1'b1;
    bus.req_operation = op;
    bus.req_operand_1 = a;
    bus.req_operand_2 = b;
    bus.req_rd        = rd;
    start  = cyc;
    waited = 0;
    while (!bus.req_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 80'(bus.req_ready), 80'(1));
      bus.req_valid = 1'b0;
      return;
    end
    k = cyc;
    exp_acc = (start > next_free) ? start : next_free;
    check("accept_cycle", 80'(k), 80'(exp_acc));

    if (op == FPU_SQRT && a[WIDTH-1]) begin
      err = 1'b1; d = '0; lat = 1;
    end else if (delay < 0 || delay >= TIMEOUT) begin
      err = 1'b1; d = '0; lat = 2 + TIMEOUT;
    end else begin
      err = 1'b0; d = fx_ref(op, a, b); lat = 3 + delay;
    end
    exp_q.push_back({32'(k + lat), err, rd, d});
    next_free = k + lat + 1;

    acc_cyc   = k;
    cfg_delay = delay;
    last_op   = op;
    last_a    = a;
    last_b    = b;
    hold_from = k + 1;
    hold_chk  = 1'b1;

    @(posedge clk);
    #1;
    bus.req_valid     = 1'b0;
    bus.req_operation = 2'($urandom_range(0, 3));
    bus.req_operand_1 = $urandom;
    bus.req_operand_2 = $urandom;
    bus.req_rd        = RD_BITS'($urandom);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (reset) begin
      if (bus.wb_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb", 80'(bus.wb_valid), 80'(0));
        end else begin
          e = exp_q.pop_front();
          check("wb_cycle", 80'(cyc), 80'(e[EXP_W-1 -: 32]));
          check("wb_error", 80'(bus.wb_error), 80'(e[WIDTH+RD_BITS]));
          check("wb_rd", 80'(bus.wb_rd), 80'(e[WIDTH +: RD_BITS]));
          check("wb_data", 80'(bus.wb_data), 80'(e[WIDTH-1:0]));
        end
      end
      if (hold_chk && cyc >= hold_from) begin
        check("fpu_hold", {14'b0, bus.fpu_operation, bus.fpu_operand_1, bus.fpu_operand_2},
              {14'b0, last_op, last_a, last_b});
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, 80'(bus.req_ready), 80'(1));
    check({tag, "_wb_valid"},  80'(bus.wb_valid),  80'(0));
    check({tag, "_wb_error"},  80'(bus.wb_error),  80'(0));
    check({tag, "_wb_rd"},     80'(bus.wb_rd),     80'(0));
    check({tag, "_wb_data"},   80'(bus.wb_data),   80'(0));
    check({tag, "_fpu_op"},    80'(bus.fpu_operation), 80'(FPU_ADD));
    check({tag, "_fpu_ops"},   {16'b0, bus.fpu_operand_1, bus.fpu_operand_2}, 80'(0));
    check({tag, "_state"},     80'(dbg_state), 80'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    logic [1:0] op;
    logic [WIDTH-1:0] a, b;
    int delay;

    bus.req_valid     = 1'b0;
    bus.req_operation = FPU_ADD;
    bus.req_operand_1 = '0;
    bus.req_operand_2 = '0;
    bus.req_rd        = '0;

    #2 reset = 1'b0;
    #1 check_reset_values("rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // directed cases
    issue(FPU_ADD,  32'h600, 32'h900, 5'd3, 0);
    issue(FPU_MUL,  32'h600, 32'h600, 5'd4, 5);   // held while ADD busy; stale ready
    issue(FPU_SQRT, 32'h900, 32'h0,   5'd5, 10);
    issue(FPU_SQRT, 32'h8000_0000, 32'h1234, 5'd6, 0);
    issue(FPU_MUL,  32'h600, 32'h600, 5'd8, -1);  // never ready -> timeout
    issue(FPU_ADD,  32'h100, 32'h200, 5'd0, 0);

    // reset during WAIT of a MUL
    issue(FPU_MUL,  32'h600, 32'h600, 5'd7, -1);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_values("mid_rst");
    exp_q.delete();
    hold_chk  = 1'b0;
    next_free = 0;
    @(negedge clk);
    reset = 1'b1;
    repeat (TIMEOUT + 10) @(negedge clk);
    issue(FPU_SUB,  32'h900, 32'h600, 5'd10, 0);

    // randomized ops
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (op == FPU_SQRT && $urandom_range(0, 2) != 0) a[WIDTH-1] = 1'b0;
      if (op == FPU_ADD || op == FPU_SUB) delay = 0;
      else if ($urandom_range(0, 9) == 0) delay = -1;
      else delay = $urandom_range(0, 12);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(op, a, b, RD_BITS'($urandom), delay);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("drain", 80'(exp_q.size()), 80'(0));
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
